button_bank_debouncer: RTL and testbench

Multi-channel debouncer with its own sample-tick divider, replacing the single-button debouncer and its separate divider at board top level. Each of N_BTN raw push-button inputs is synchronised, sampled on a shared slow tick and accepted only after STABLE_SAMPLES consecutive agreeing samples. Per channel it produces a debounced level, one-clock press and release pulses, and an optional long-press pulse. Everything runs in the single system clock domain; the slow tick is a clock enable, not a derived clock.

---
 rtl/button_bank_debouncer.sv | 128 ++++++++++++
 tb/tb_button_bank_debouncer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/button_bank_debouncer.sv
// Multi-channel push-button debouncer with a shared sample-tick divider (clock enable).
// Long-press detection is built only when BUTTON_BANK_LONG_PRESS_EN is defined.
module button_bank_debouncer #(
   parameter int N_BTN          = 4,
   parameter int TICK_DIV       = 12000,
   parameter int STABLE_SAMPLES = 4,
   parameter int LONG_TICKS     = 500
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] b_in,
   output logic [N_BTN-1:0] b_level,
   output logic [N_BTN-1:0] b_press,
   output logic [N_BTN-1:0] b_release,
   output logic [N_BTN-1:0] b_long,
   output logic             b_any
);

   localparam int TDIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SCNT_W = $clog2(STABLE_SAMPLES + 1);
   localparam logic [TDIV_W-1:0] TDIV_LAST = TDIV_W'(TICK_DIV - 1);
   localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STABLE_SAMPLES - 1);

   logic [N_BTN-1:0]  sync_p0;
   logic [N_BTN-1:0]  sync_p1;
   logic [TDIV_W-1:0] tdiv;
   logic              tick;
   logic [SCNT_W-1:0] scnt [N_BTN];
   logic [N_BTN-1:0]  flip;

   function automatic logic [SCNT_W-1:0] scnt_inc(input logic [SCNT_W-1:0] v);
      return v + SCNT_W'(1);
   endfunction

   // Stage p0/p1: two-flop synchroniser on the raw asynchronous inputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= b_in;
         sync_p1 <= sync_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tdiv <= '0;
      end else if (tick) begin
         tdiv <= '0;
      end else begin
         tdiv <= tdiv + TDIV_W'(1);
      end
   end

   assign tick = (tdiv == TDIV_LAST);

   // A channel accepts its new level on the tick that completes the disagreeing run
   always_comb begin
      flip = '0;
      for (int i = 0; i < N_BTN; i++) begin
         flip[i] = tick && (sync_p1[i] != b_level[i]) && (scnt[i] == SCNT_LAST);
      end
   end

   // Stage p2: registered level, edge pulses and stability counters
   always_ff @(posedge clk) begin
      if (!rst) begin
         b_level   <= '0;
         b_press   <= '0;
         b_release <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            scnt[i] <= '0;
         end
      end else begin
         b_level   <= b_level ^ flip;
         b_press   <= flip & sync_p1;
         b_release <= flip & ~sync_p1;
         if (tick) begin
            for (int i = 0; i < N_BTN; i++) begin
               if ((sync_p1[i] == b_level[i]) || flip[i]) begin
                  scnt[i] <= '0;
               end else begin
                  scnt[i] <= scnt_inc(scnt[i]);
               end
            end
         end
      end
   end

`ifdef BUTTON_BANK_LONG_PRESS_EN
   localparam int LCNT_W = $clog2(LONG_TICKS + 1);
   localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LONG_TICKS);
   localparam logic [LCNT_W-1:0] LCNT_PRE = LCNT_W'(LONG_TICKS - 1);

   logic [LCNT_W-1:0] lcnt [N_BTN];

   function automatic logic [LCNT_W-1:0] lcnt_sat_inc(input logic [LCNT_W-1:0] v);
      return (v == LCNT_MAX) ? v : v + LCNT_W'(1);
   endfunction

   // A falling flip clears the hold count on the same tick, so release beats long-press
   always_ff @(posedge clk) begin
      if (!rst) begin
         b_long <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            lcnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            b_long[i] <= 1'b0;
            if (!b_level[i] || flip[i]) begin
               lcnt[i] <= '0;
            end else if (tick) begin
               lcnt[i]   <= lcnt_sat_inc(lcnt[i]);
               b_long[i] <= (lcnt[i] == LCNT_PRE);
            end
         end
      end
   end
`else
   // LONG_TICKS has no effect in this build; the term is constant zero.
   assign b_long = {N_BTN{LONG_TICKS < 0}};
`endif

   assign b_any = |b_level;

endmodule

// File: tb/tb_button_bank_debouncer.sv
// Scoreboard bench for button_bank_debouncer: a sample-window reference model predicts every cycle.
module tb_button_bank_debouncer;

   localparam int N_BTN          = 2;
   localparam int TICK_DIV       = 4;
   localparam int STABLE_SAMPLES = 3;
   localparam int LONG_TICKS     = 5;
`ifdef BUTTON_BANK_LONG_PRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [N_BTN-1:0] b_in;
   logic [N_BTN-1:0] b_level;
   logic [N_BTN-1:0] b_press;
   logic [N_BTN-1:0] b_release;
   logic [N_BTN-1:0] b_long;
   logic             b_any;

   always #5 clk = ~clk;

   button_bank_debouncer #(
      .N_BTN(N_BTN),
      .TICK_DIV(TICK_DIV),
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .LONG_TICKS(LONG_TICKS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .b_in(b_in),
      .b_level(b_level),
      .b_press(b_press),
      .b_release(b_release),
      .b_long(b_long),
      .b_any(b_any)
   );

   typedef struct packed {
      logic [N_BTN-1:0] level;
      logic [N_BTN-1:0] press;
      logic [N_BTN-1:0] rel;
      logic [N_BTN-1:0] lng;
      logic             any;
      logic             tck;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: edges since reset, input history, recent tick samples, rise tick index
   int               m_n;
   int               m_ntick;
   logic [N_BTN-1:0] m_d1;
   logic [N_BTN-1:0] m_d2;
   logic [N_BTN-1:0] m_level;
   logic [N_BTN-1:0] m_tsmp[$];
   int               m_rise [N_BTN];
   logic [N_BTN-1:0] cur;

   task automatic model_edge(input logic rn, input logic [N_BTN-1:0] bin, output exp_t e);
      logic [N_BTN-1:0] s;
      bit               all_diff;
      e = '0;
      if (!rn) begin
         m_n     = 0;
         m_ntick = 0;
         m_d1    = '0;
         m_d2    = '0;
         m_level = '0;
         m_tsmp.delete();
      end else begin
         m_n++;
         s    = m_d2;
         m_d2 = m_d1;
         m_d1 = bin;
         if (m_n % TICK_DIV == 0) begin
            m_ntick++;
            m_tsmp.push_back(s);
            if (m_tsmp.size() > STABLE_SAMPLES) void'(m_tsmp.pop_front());
            for (int ch = 0; ch < N_BTN; ch++) begin
               all_diff = (m_tsmp.size() == STABLE_SAMPLES);
               for (int k = 0; k < m_tsmp.size(); k++) begin
                  if (m_tsmp[k][ch] == m_level[ch]) all_diff = 1'b0;
               end
               if (all_diff) begin
                  if (s[ch]) begin
                     e.press[ch] = 1'b1;
                     m_rise[ch]  = m_ntick;
                  end else begin
                     e.rel[ch] = 1'b1;
                  end
               end else if (LONG_EN && m_level[ch] && (m_ntick - m_rise[ch] == LONG_TICKS)) begin
                  e.lng[ch] = 1'b1;
               end
            end
            m_level = m_level ^ (e.press | e.rel);
         end
         e.tck = (m_n % TICK_DIV == TICK_DIV - 1);
      end
      e.level = m_level;
      e.any   = |m_level;
   endtask

   task automatic drive(input logic rn, input logic [N_BTN-1:0] bin);
      exp_t e;
      @(negedge clk);
      rst  = rn;
      b_in = bin;
      model_edge(rn, bin, e);
      exp_q.push_back(e);
   endtask

   task automatic hold(input int n, input logic [N_BTN-1:0] bin);
      for (int i = 0; i < n; i++) drive(1'b1, bin);
   endtask

   function automatic void check(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
      end
   endfunction

   // Monitor: every DUT output cycle is matched against the oldest prediction
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("b_level",   16'(b_level),   16'(e.level));
            check("b_press",   16'(b_press),   16'(e.press));
            check("b_release", 16'(b_release), 16'(e.rel));
            check("b_long",    16'(b_long),    16'(e.lng));
            check("b_any",     16'(b_any),     16'(e.any));
            check("tick",      16'(dut.tick),  16'(e.tck));
         end
      end
   end

   initial begin : stimulus
      int p_flip;
      rst  = 1'b0;
      b_in = '0;
      repeat (3) drive(1'b0, 2'b00);
      hold(40, 2'b00);
      // clean press and release on channel 0
      hold(24, 2'b01);
      hold(24, 2'b00);
      // bounce 1,0,1 one tick each, then steady high
      hold(4, 2'b01);
      hold(4, 2'b00);
      hold(4, 2'b01);
      hold(24, 2'b01);
      hold(24, 2'b00);
      // both channels together
      hold(24, 2'b11);
      hold(24, 2'b00);
      // long press on channel 1, released and re-armed
      hold(48, 2'b10);
      hold(24, 2'b00);
      hold(48, 2'b10);
      hold(24, 2'b00);
      // reset for one clock mid-hold
      hold(20, 2'b01);
      drive(1'b0, 2'b01);
      hold(24, 2'b01);
      hold(24, 2'b00);
      // randomized bursts alternating between bouncy and calm phases
      cur = '0;
      for (int c = 0; c < 4000; c++) begin
         p_flip = ((c / 200) % 2 == 0) ? 3 : 40;
         if ($urandom_range(0, p_flip - 1) == 0) cur[$urandom_range(0, N_BTN - 1)] ^= 1'b1;
         drive(($urandom_range(0, 599) != 0), cur);
      end
      repeat (3) @(negedge clk);
      check("drain", 16'(exp_q.size()), 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
